counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_pkg.sv | 27 ++
 rtl/bcd_digit.sv | 38 +++
 rtl/counter_ctrl.sv | 144 ++++++++++++++
 tb/tb_counter_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the BCD up/down counter controller.
//   state_t      : FSM state encoding
//   BCD_MAX      : largest legal BCD digit
//   UP_TERM /
//   DOWN_TERM    : terminal count for each direction, packed {tens, ones}
//   *_PRE_TERM   : value one step before each terminal
//   bcd_sat()    : clamps a preset digit into 0..9
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam logic [7:0] UP_TERM        = 8'h99;
    localparam logic [7:0] DOWN_TERM      = 8'h00;
    localparam logic [7:0] UP_PRE_TERM    = 8'h98;
    localparam logic [7:0] DOWN_PRE_TERM  = 8'h01;

    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with load and up/down step.
//   clk, rst : clock, async active-high reset (digit -> 0)
//   en       : step this digit by one this cycle
//   dir      : 0 = up, 1 = down
//   ld       : load ld_val (saturated to 9); has priority over en
//   ld_val   : raw preset digit
//   val      : current digit
//   wrap     : combinational, high when a step would wrap (9 up, 0 down)
module bcd_digit
    import counter_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] val,
    output logic       wrap
);

    assign wrap = dir ? (val == 4'd0) : (val == BCD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= 4'd0;
        end else if (ld) begin
            val <= bcd_sat(ld_val);
        end else if (en) begin
            if (dir) begin
                val <= wrap ? BCD_MAX : val - 4'd1;
            end else begin
                val <= wrap ? 4'd0 : val + 4'd1;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Two-digit BCD up/down counter with start/stop, pause and preset load.
//   TICK_DIV    : clk cycles per count step (>= 1)
//   clk, rst    : clock, async active-high reset
//   SS          : start/stop pulse
//   u           : direction, 0 = up, 1 = down (sampled on each tick)
//   load        : preset load pulse (wins over SS)
//   preset_*    : BCD preset digits, values > 9 saturate to 9
//   cnt_*       : current BCD count
//   running     : high while in RUN
//   done        : high while in DONE
//
// state | meaning
// IDLE  | stopped, count held, waiting for SS or load
// RUN   | prescaler advancing, count steps on each tick
// PAUSE | stopped mid-run, prescaler value held for resume
// DONE  | terminal count reached, waiting for SS or load
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS,
    input  logic       u,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t          state, state_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic            tick, at_term, lands, step, ld;
    logic            ones_wrap, tens_wrap;

    assign tick = (presc == PRESC_LAST);

    // Both digits wrapping in the current direction means 99 (up) or 00 (down).
    assign at_term = ones_wrap & tens_wrap;
    assign lands   = ({cnt_tens, cnt_ones} == (u ? DOWN_PRE_TERM : UP_PRE_TERM));

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        step      = 1'b0;
        ld        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    ld        = 1'b1;
                    presc_nxt = '0;
                end else if (SS) begin
                    state_nxt = ST_RUN;
                    presc_nxt = '0;
                end
            end
            ST_RUN: begin
                // SS freezes the prescaler, so a coincident tick is lost and
                // the resume lands on the tick after one cycle.
                if (SS) begin
                    state_nxt = ST_PAUSE;
                end else if (tick) begin
                    presc_nxt = '0;
                    if (at_term) begin
                        state_nxt = ST_DONE;
                    end else begin
                        step = 1'b1;
                        if (lands) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    ld        = 1'b1;
                    presc_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (SS) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load) begin
                    ld        = 1'b1;
                    presc_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (SS) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                presc_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            running <= (state_nxt == ST_RUN);
            done    <= (state_nxt == ST_DONE);
        end
    end

    bcd_digit u_ones (
        .clk    (clk),
        .rst    (rst),
        .en     (step),
        .dir    (u),
        .ld     (ld),
        .ld_val (preset_ones),
        .val    (cnt_ones),
        .wrap   (ones_wrap)
    );

    bcd_digit u_tens (
        .clk    (clk),
        .rst    (rst),
        .en     (step & ones_wrap),
        .dir    (u),
        .ld     (ld),
        .ld_val (preset_tens),
        .val    (cnt_tens),
        .wrap   (tens_wrap)
    );

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

    localparam int TD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS;
    logic       u;
    logic       load;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic [3:0] cnt_tens;
    logic [3:0] cnt_ones;
    logic       running;
    logic       done;

    int total = 0;
    int bad   = 0;

    counter_ctrl #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst         (rst),
        .SS          (SS),
        .u           (u),
        .load        (load),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .cnt_tens    (cnt_tens),
        .cnt_ones    (cnt_ones),
        .running     (running),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        SS   = 1'b0;
        load = 1'b0;
        u    = 1'b0;
        preset_tens = 4'd0;
        preset_ones = 4'd0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        preset_tens = t;
        preset_ones = o;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic pulse_ss();
        SS = 1'b1;
        cyc();
        SS = 1'b0;
    endtask

    function automatic int cnt_now();
        return {24'd0, cnt_tens, cnt_ones};
    endfunction

    // ---------------- reference model (integer count, phase counter) -----
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    int m_mode, m_cnt, m_ph;

    function automatic int sat9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic model_step();
        int preset;
        int term;
        preset = sat9(int'(preset_tens)) * 10 + sat9(int'(preset_ones));
        term   = u ? 0 : 99;
        case (m_mode)
            M_IDLE: begin
                if (load) begin
                    m_cnt = preset;
                    m_ph  = 0;
                end else if (SS) begin
                    m_mode = M_RUN;
                    m_ph   = 0;
                end
            end
            M_RUN: begin
                if (SS) begin
                    m_mode = M_PAUSE;
                end else if (m_ph == TD - 1) begin
                    m_ph = 0;
                    if (m_cnt == term) begin
                        m_mode = M_DONE;
                    end else begin
                        m_cnt = m_cnt + (u ? -1 : 1);
                        if (m_cnt == term) m_mode = M_DONE;
                    end
                end else begin
                    m_ph = m_ph + 1;
                end
            end
            M_PAUSE: begin
                if (load) begin
                    m_cnt  = preset;
                    m_ph   = 0;
                    m_mode = M_IDLE;
                end else if (SS) begin
                    m_mode = M_RUN;
                end
            end
            default: begin
                if (load) begin
                    m_cnt  = preset;
                    m_ph   = 0;
                    m_mode = M_IDLE;
                end else if (SS) begin
                    m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    // ---------------- vector table ----------------------------------------
    typedef struct {
        logic [3:0] pt;
        logic [3:0] po;
        logic       dir;
        logic [7:0] exp_load;
        logic [7:0] exp_step;
        logic       exp_done;
        logic       exp_run;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'h1, 4'h5, 1'b0, 8'h15, 8'h16, 1'b0, 1'b1};
        vecs[1] = '{4'h0, 4'h9, 1'b0, 8'h09, 8'h10, 1'b0, 1'b1};
        vecs[2] = '{4'h1, 4'h0, 1'b1, 8'h10, 8'h09, 1'b0, 1'b1};
        vecs[3] = '{4'h9, 4'h8, 1'b0, 8'h98, 8'h99, 1'b1, 1'b0};
        vecs[4] = '{4'h0, 4'h1, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{4'h0, 4'h0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{4'h9, 4'h9, 1'b0, 8'h99, 8'h99, 1'b1, 1'b0};
        vecs[7] = '{4'hC, 4'h7, 1'b0, 8'h97, 8'h98, 1'b0, 1'b1};
        vecs[8] = '{4'h5, 4'hF, 1'b1, 8'h59, 8'h58, 1'b0, 1'b1};
        vecs[9] = '{4'h5, 4'h0, 1'b1, 8'h50, 8'h49, 1'b0, 1'b1};

        // reset state
        do_reset();
        chk("reset_cnt", cnt_now(), 'h00);
        chk("reset_run_done", {running, done}, 2'b00);

        // table: load, start, first tick
        for (int i = 0; i < 10; i++) begin
            do_reset();
            u = vecs[i].dir;
            do_load(vecs[i].pt, vecs[i].po);
            chk($sformatf("v%0d_load", i), cnt_now(), vecs[i].exp_load);
            chk($sformatf("v%0d_idle", i), {running, done}, 2'b00);
            pulse_ss();
            chk($sformatf("v%0d_start", i), {running, done}, 2'b10);
            cyc();
            cyc();
            chk($sformatf("v%0d_step", i), cnt_now(), vecs[i].exp_step);
            chk($sformatf("v%0d_flags", i), {running, done},
                {vecs[i].exp_run, vecs[i].exp_done});
        end

        // 15 up: 16 after two cycles, 17 after four, running throughout
        do_reset();
        do_load(4'h1, 4'h5);
        pulse_ss();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("seq15_run%0d", k), running, 1'b1);
            if (k == 1) chk("seq15_c1", cnt_now(), 'h15);
            if (k == 2) chk("seq15_c2", cnt_now(), 'h16);
            if (k == 4) chk("seq15_c4", cnt_now(), 'h17);
        end

        // 01 down -> 00 DONE, SS -> IDLE, restart down -> DONE unchanged
        do_reset();
        u = 1'b1;
        do_load(4'h0, 4'h1);
        pulse_ss();
        cyc();
        cyc();
        chk("dn_done_cnt", cnt_now(), 'h00);
        chk("dn_done_flags", {running, done}, 2'b01);
        pulse_ss();
        chk("dn_idle_flags", {running, done}, 2'b00);
        chk("dn_idle_cnt", cnt_now(), 'h00);
        pulse_ss();
        chk("dn_rerun", {running, done}, 2'b10);
        cyc();
        cyc();
        chk("dn_term_cnt", cnt_now(), 'h00);
        chk("dn_term_flags", {running, done}, 2'b01);

        // pause on a tick, hold, resume with held prescaler
        do_reset();
        do_load(4'h2, 4'h0);
        pulse_ss();
        cyc();
        SS = 1'b1;
        cyc();
        SS = 1'b0;
        chk("pause_cnt", cnt_now(), 'h20);
        chk("pause_flags", {running, done}, 2'b00);
        repeat (20) cyc();
        chk("pause_hold_cnt", cnt_now(), 'h20);
        chk("pause_hold_flags", {running, done}, 2'b00);
        pulse_ss();
        chk("resume_run", {running, done}, 2'b10);
        chk("resume_cnt0", cnt_now(), 'h20);
        cyc();
        chk("resume_step", cnt_now(), 'h21);

        // saturating preset, load wins over SS in IDLE
        do_reset();
        do_load(4'hC, 4'h7);
        chk("sat_load", cnt_now(), 'h97);
        preset_tens = 4'h3;
        preset_ones = 4'h4;
        load = 1'b1;
        SS   = 1'b1;
        cyc();
        load = 1'b0;
        SS   = 1'b0;
        chk("ld_ss_cnt", cnt_now(), 'h34);
        chk("ld_ss_flags", {running, done}, 2'b00);
        cyc();
        chk("ld_ss_stay", {running, done}, 2'b00);

        // async reset mid-RUN
        do_reset();
        do_load(4'h4, 4'h5);
        pulse_ss();
        cyc();
        cyc();
        chk("pre_rst_cnt", cnt_now(), 'h46);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cnt", cnt_now(), 'h00);
        chk("async_rst_flags", {running, done}, 2'b00);
        #2 rst = 1'b0;
        repeat (6) cyc();
        chk("post_rst_cnt", cnt_now(), 'h00);
        chk("post_rst_flags", {running, done}, 2'b00);
        pulse_ss();
        cyc();
        cyc();
        chk("post_rst_run", cnt_now(), 'h01);

        // randomized against the reference model
        do_reset();
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_ph   = 0;
        for (int i = 0; i < 2000; i++) begin
            SS   = ($urandom_range(7) == 0);
            load = ($urandom_range(15) == 0);
            if ($urandom_range(9) == 0) u = ~u;
            preset_tens = 4'($urandom_range(15));
            preset_ones = 4'($urandom_range(15));
            @(posedge clk);
            model_step();
            #1;
            chk("rand_cnt", cnt_now(), to_bcd(m_cnt));
            chk("rand_flags", {running, done},
                {(m_mode == M_RUN), (m_mode == M_DONE)});
        end
        SS   = 1'b0;
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
